fp_round_arbiter: RTL
=====================

# fp_round_arbiter

Shares one single-precision rounding unit (raw-to-recoded, 27-bit significand, 10-bit signed exponent, 33-bit recoded result) between two raw-result producers: requester 0 is the FMA pipe and requester 1 is the div/sqrt unit. The block contains a round-robin arbiter, a two-stage valid/ready pipeline around the rounding logic, and a flush path. Results return to a single consumer with the source ID and tag attached. It sits between the FP execution units and the FP writeback mux.

## Interface
Parameters:
- TAG_W, 5, width of the opaque per-request tag that is carried through to the result.

Ports (N = 0, 1):
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_detectTininess  in  1  global tininess mode passed to the rounder (1 = after rounding).
- io_flush  in  1  synchronous kill of all in-flight requests.
- io_reqN_valid  in  1  request N present.
- io_reqN_ready  out  1  request N accepted this cycle when high together with valid.
- io_reqN_invalidExc / io_reqN_infiniteExc  in  1 each  exception inputs to the rounder.
- io_reqN_isNaN / isInf / isZero / sign  in  1 each  raw classification fields.
- io_reqN_sExp  in  10  raw signed exponent.
- io_reqN_sig  in  27  raw significand, including guard/sticky bits.
- io_reqN_roundingMode  in  3  IEEE rounding mode (RNE = 0, RTZ = 1, RDN = 2, RUP = 3, RMM = 4).
- io_reqN_tag  in  TAG_W  opaque tag.
- io_resp_valid  out  1  result present.
- io_resp_ready  in  1  consumer accepts the result.
- io_resp_src  out  1  requester index of the result.
- io_resp_tag  out  TAG_W  tag of the result.
- io_resp_out  out  33  recoded result.
- io_resp_exceptionFlags  out  5  NV, DZ, OF, UF, NX.
- io_busy  out  1  high when either stage holds a valid entry.

## Operation
- **Stage S1 register.** Holds the raw fields, src, and tag of the granted request, plus an s1_valid bit.
- **Rounding logic.** Combinational rounding logic (instance of the team's raw-to-recoded rounder) is driven from S1.
- **Stage S2 register.** Holds out, exceptionFlags, src, and tag, plus an s2_valid bit. S2 drives io_resp_* directly.
- **Advance rules.**
  - s2_free = !s2_valid | io_resp_ready.
  - s1_free = !s1_valid | s2_free.
  - S1 moves to S2 when s1_valid & s2_free.
  - A new request enters S1 when it is granted and s1_free.
- **Arbitration.**
  - A 1-bit pointer `last` records the most recently accepted source.
  - If only one request is valid, it is granted.
  - If both are valid, the source != last is granted.
  - `last` updates only on an accepted handshake. A grant without acceptance does not move it.
- **Ready signals.** io_reqN_ready = grantN & s1_free & !io_flush.
  - ready may depend combinationally on io_resp_ready and on the other requester's valid.
  - Requesters must not make valid depend on ready.
  - A requester holds valid and its fields stable until accepted.
- **Flush.** When io_flush is high at a clock edge:
  - s1_valid and s2_valid are cleared.
  - No request is accepted and `last` is unchanged.
  - A response handshaking in the same cycle still counts as consumed.
- **Reset state.** s1_valid = 0, s2_valid = 0, last = 1 (req0 wins the first tie), all S1/S2 data registers = 0. Resulting outputs:
  - io_resp_valid = 0, io_resp_src = 0, io_resp_tag = 0, io_resp_out = 0, io_resp_exceptionFlags = 0, io_busy = 0.
  - io_reqN_ready follows the combinational rule, so io_req0_ready = io_req0_valid.
- **Reset mid-operation.** Asserting reset clears both stages immediately (asynchronously). In-flight results are lost without a response.

## Timing
- **Latency.** A request accepted at edge k gives io_resp_valid high after edge k+1, i.e. 2 cycles from the handshake to the result being visible.
- **Throughput.** 1 result per cycle while io_resp_ready = 1. Both requesters continuously valid alternate 0, 1, 0, 1.
- **Backpressure.**
  - With io_resp_ready = 0, S2 holds its value and S1 fills.
  - After 2 accepts, both io_reqN_ready are 0.
  - When io_resp_ready rises, S2 drains, S1 advances, and a new accept occurs in the same cycle (full-rate recovery with no bubble).
- **Output stability.** io_resp_* are stable while io_resp_valid & !io_resp_ready.
- **Ordering.** Results leave in acceptance order.

## Test plan
- **Single request.** Reset, then req0 with sig = 27'h4000000, sExp = 10'h100, isZero = 0, sign = 0, RNE, tag = 3 → two cycles later resp_valid = 1, src = 0, tag = 3, out = 33'h080000000 (1.0f recoded), flags = 0.
- **Contention.** Both requesters valid for 6 cycles, resp_ready = 1 → accepted src order 0, 1, 0, 1, 0, 1, with tags preserved and 1 result per cycle.
- **Backpressure.**
  - Stimulus: hold resp_ready = 0 while 3 requests are offered.
  - Response: exactly 2 are accepted, ready drops, and resp_* stays frozen.
  - Then release resp_ready: results come out in order, and the third request is accepted in the release cycle.
- **Flush.** Pulse io_flush with both stages full → next cycle resp_valid = 0, busy = 0, and no request is accepted in the flush cycle.
- **Exceptions.** req1 with invalidExc = 1 → flags = 5'b10000 and out = canonical NaN 33'h0E0400000. Overflow with sExp = 10'h1FF under RTZ → out = max finite, flags = OF | NX = 5'b00101.
- **Async reset.** Assert reset mid-stream with both stages valid → resp_valid drops without waiting for a clock edge. After release, req0 wins the first tie.

Source files
------------

// File: rtl/fp_round_arbiter.sv
// fp_round_arbiter: round-robin sharing of one raw-to-recoded FP32 rounder between FMA and div/sqrt.
module fp_round_raw_to_rec (
  input  logic        detectTininess,
  input  logic        invalidExc,
  input  logic        infiniteExc,
  input  logic        isNaN,
  input  logic        isInf,
  input  logic        isZero,
  input  logic        sign,
  input  logic [9:0]  sExp,
  input  logic [26:0] sig,
  input  logic [2:0]  roundingMode,
  output logic [32:0] out,
  output logic [4:0]  exceptionFlags
);
  function automatic logic roundInc(input logic [2:0] rm, input logic neg, input logic lsb,
                                    input logic grd, input logic stk);
    return rm == 3'd0 ? grd & (stk | lsb)
         : rm == 3'd2 ? neg & (grd | stk)
         : rm == 3'd3 ? !neg & (grd | stk)
         : rm == 3'd4 ? grd : 1'b0;
  endfunction
  logic signed [10:0] xExp, clampExp, rExp;
  logic [4:0] ulpPos;
  logic [28:0] ext, ulp, lowMask, rounded;
  logic [22:0] frac;
  logic guard, sticky, inexact, carryNorm, tiny, overflow, toInf, zeroRes;
  logic [32:0] infOut;
  // sig[26] is the integer bit; below exponent 130 the rounding point slides up into the fraction
  assign xExp = {sExp[9], sExp};
  assign clampExp = xExp < 11'sd105 ? 11'sd105 : xExp;
  assign ulpPos = clampExp >= 11'sd130 ? 5'd3 : 5'(11'sd133 - clampExp);
  assign ext = {2'b0, sig};
  assign ulp = 29'd1 << ulpPos;
  assign lowMask = ulp - 29'd1;
  assign guard = |(ext & (ulp >> 1));
  assign sticky = |(ext & (lowMask >> 1));
  assign inexact = guard | sticky;
  assign rounded = (ext & ~lowMask) + (roundInc(roundingMode, sign, |(ext & ulp), guard, sticky) ? ulp : 29'd0);
  assign rExp = rounded[28] ? clampExp + 11'sd2 : rounded[27] ? clampExp + 11'sd1 : clampExp;
  assign frac = rounded[28] ? 23'd0 : rounded[27] ? rounded[26:4] : rounded[25:3];
  assign zeroRes = !(|rounded[28:26]);
  // tininess after rounding: only exponent 129 can be rescued by an unbounded-range carry
  assign carryNorm = (&sig[26:3]) & roundInc(roundingMode, sign, sig[3], sig[2], |sig[1:0]);
  assign tiny = (xExp < 11'sd130) && !(detectTininess && (xExp == 11'sd129) && carryNorm);
  assign overflow = rExp > 11'sd383;
  assign toInf = roundingMode == 3'd0 || roundingMode == 3'd4 || (roundingMode == 3'd2 && sign)
              || (roundingMode == 3'd3 && !sign);
  assign infOut = {sign, 9'h180, 23'd0};
  always_comb begin
    out = zeroRes ? {sign, 32'd0} : {sign, rExp[8:0], frac};
    exceptionFlags = {3'b000, tiny & inexact, inexact};
    if (invalidExc | isNaN) begin
      out = 33'h0E0400000;
      exceptionFlags = {invalidExc, 4'b0000};
    end else if (infiniteExc | isInf) begin
      out = infOut;
      exceptionFlags = {1'b0, infiniteExc, 3'b000};
    end else if (isZero) begin
      out = {sign, 32'd0};
      exceptionFlags = 5'b00000;
    end else if (overflow) begin
      out = toInf ? infOut : {sign, 9'h17F, 23'h7FFFFF};
      exceptionFlags = 5'b00101;
    end
  end
endmodule

module fp_round_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_detectTininess,
  input  logic             io_flush,
  input  logic             io_req0_valid,
  output logic             io_req0_ready,
  input  logic             io_req0_invalidExc,
  input  logic             io_req0_infiniteExc,
  input  logic             io_req0_isNaN,
  input  logic             io_req0_isInf,
  input  logic             io_req0_isZero,
  input  logic             io_req0_sign,
  input  logic [9:0]       io_req0_sExp,
  input  logic [26:0]      io_req0_sig,
  input  logic [2:0]       io_req0_roundingMode,
  input  logic [TAG_W-1:0] io_req0_tag,
  input  logic             io_req1_valid,
  output logic             io_req1_ready,
  input  logic             io_req1_invalidExc,
  input  logic             io_req1_infiniteExc,
  input  logic             io_req1_isNaN,
  input  logic             io_req1_isInf,
  input  logic             io_req1_isZero,
  input  logic             io_req1_sign,
  input  logic [9:0]       io_req1_sExp,
  input  logic [26:0]      io_req1_sig,
  input  logic [2:0]       io_req1_roundingMode,
  input  logic [TAG_W-1:0] io_req1_tag,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic             io_resp_src,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic [32:0]      io_resp_out,
  output logic [4:0]       io_resp_exceptionFlags,
  output logic             io_busy
);
  localparam int DW = TAG_W + 46;
  logic s1Valid, s2Valid, last, s1Src, s2Src;
  logic grant0, grant1, s2Free, s1Free;
  logic [DW-1:0] reqBits0, reqBits1, s1Data;
  logic [TAG_W-1:0] s1Tag, s2Tag;
  logic [2:0] s1Rm;
  logic s1Inv, s1InfExc, s1NaN, s1Inf, s1Zero, s1Sign;
  logic [9:0] s1SExp;
  logic [26:0] s1Sig;
  logic [32:0] rOut, s2Out;
  logic [4:0] rFlags, s2Flags;
  assign reqBits0 = {io_req0_tag, io_req0_roundingMode, io_req0_invalidExc, io_req0_infiniteExc,
                     io_req0_isNaN, io_req0_isInf, io_req0_isZero, io_req0_sign, io_req0_sExp, io_req0_sig};
  assign reqBits1 = {io_req1_tag, io_req1_roundingMode, io_req1_invalidExc, io_req1_infiniteExc,
                     io_req1_isNaN, io_req1_isInf, io_req1_isZero, io_req1_sign, io_req1_sExp, io_req1_sig};
  assign {s1Tag, s1Rm, s1Inv, s1InfExc, s1NaN, s1Inf, s1Zero, s1Sign, s1SExp, s1Sig} = s1Data;
  // on a tie the source that did not win last time gets the grant
  assign grant0 = io_req0_valid & (!io_req1_valid | last);
  assign grant1 = io_req1_valid & (!io_req0_valid | !last);
  assign s2Free = !s2Valid | io_resp_ready;
  assign s1Free = !s1Valid | s2Free;
  assign io_req0_ready = grant0 & s1Free & !io_flush;
  assign io_req1_ready = grant1 & s1Free & !io_flush;
  assign io_resp_valid = s2Valid;
  assign io_resp_src = s2Src;
  assign io_resp_tag = s2Tag;
  assign io_resp_out = s2Out;
  assign io_resp_exceptionFlags = s2Flags;
  assign io_busy = s1Valid | s2Valid;
  fp_round_raw_to_rec rounder (
    .detectTininess(io_detectTininess),
    .invalidExc(s1Inv),
    .infiniteExc(s1InfExc),
    .isNaN(s1NaN),
    .isInf(s1Inf),
    .isZero(s1Zero),
    .sign(s1Sign),
    .sExp(s1SExp),
    .sig(s1Sig),
    .roundingMode(s1Rm),
    .out(rOut),
    .exceptionFlags(rFlags)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
      last <= 1'b1;
      s1Src <= 1'b0;
      s1Data <= '0;
      s2Src <= 1'b0;
      s2Tag <= '0;
      s2Out <= '0;
      s2Flags <= '0;
    end else if (io_flush) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      if (s2Free) begin
        s2Valid <= s1Valid;
        if (s1Valid) begin
          s2Src <= s1Src;
          s2Tag <= s1Tag;
          s2Out <= rOut;
          s2Flags <= rFlags;
        end
      end
      if (s1Free) begin
        s1Valid <= io_req0_ready | io_req1_ready;
        if (io_req0_ready | io_req1_ready) begin
          s1Src <= grant1;
          s1Data <= grant1 ? reqBits1 : reqBits0;
          last <= grant1;
        end
      end
    end
  end
endmodule
